tinyalu_cmd_issuer: RTL and testbench
=====================================

// Module: tinyalu_cmd_issuer
// PURPOSE
//  Upstream stage of the TinyALU. Accepts ALU commands on a valid/ready stream,
//  buffers them in a small FIFO and drives the ALU start/done protocol one op at a time.
//  Returns each result, tagged with its op and a status, on a valid/ready response stream.
//  Handles no_op, rst_op, illegal encodings and a missing done locally.
// PARAMETERS
//  FIFO_DEPTH  4   command FIFO entries (power of two, >=2)
//  TIMEOUT     15  max BUSY cycles waiting for alu_done before abort
//  RST_CYCLES  2   cycles alu_reset_n is held low for rst_op or a timeout
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   command accepted when valid&&ready
//  cmd_a        in   8   operand A
//  cmd_b        in   8   operand B
//  cmd_op       in   3   operation_t
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   response consumed when valid&&ready
//  rsp_result   out  16  result
//  rsp_op       out  3   op of this response
//  rsp_status   out  2   rsp_status_t: 00 OK, 01 TIMEOUT, 10 ILLEGAL
//  alu_A        out  8   to ALU A
//  alu_B        out  8   to ALU B
//  alu_op       out  3   to ALU op
//  alu_start    out  1   to ALU start
//  alu_reset_n  out  1   to ALU reset_n (active low)
//  alu_done     in   1   from ALU done
//  alu_result   in   16  from ALU result, valid with alu_done
// BEHAVIOUR
//  Reset: FIFO empty, FSM IDLE, cmd_ready=0 during reset, 1 after; rsp_valid=0;
//   rsp_*=0; alu_start=0; alu_A/B/op=0; alu_reset_n=0 while reset high, 1 after.
//  cmd_ready = !fifo_full (registered; no pass-through when full, even with a same-cycle pop).
//  FSM IDLE: if FIFO non-empty, pop the head and decode:
//   add/and/xor/mul -> BUSY; alu_A/B/op loaded; alu_start=1 from the next cycle.
//   no_op -> RESP, result 0, status OK, no start.
//   rst_op -> ARST, alu_reset_n=0 for RST_CYCLES, then RESP with result 0, status OK.
//   3'b101/3'b110 -> RESP, result 0, status ILLEGAL, no start.
//  BUSY: alu_start held 1, alu_A/B/op held stable; cycle counter increments.
//   alu_done=1 -> capture alu_result, alu_start=0 next cycle, go to RESP (status OK).
//   counter==TIMEOUT and no done -> alu_start=0, go to ARST, then RESP with result 0, status TIMEOUT.
//   done in the same cycle the timeout is reached -> done wins.
//  RESP: rsp_valid=1, rsp_* stable until rsp_ready; on handshake go to IDLE.
//   If the FIFO is non-empty, the next pop happens in that IDLE cycle.
//  alu_done while not BUSY is ignored.
//  Latency: accepted at cycle N into an empty FIFO with FSM in IDLE -> alu_start=1 at N+2
//   (N+1: FIFO visible, pop/decode).
//   alu_done at cycle M -> rsp_valid=1 at M+1.
//  Ordering: responses in command order; exactly one response per accepted command.
//  Capacity: FIFO_DEPTH queued plus one in the FSM.
//  Reset mid-operation: takes effect next edge. In-flight and queued commands are
//   dropped with no response, alu_start drops and the ALU is held reset.
//  FIFO pointers wrap modulo FIFO_DEPTH. Full/empty use an extra pointer bit.
// STRUCTURE
//  tinyalu_pkg: operation_t (shared with the bench), rsp_status_t, alu_cmd_t struct
//   {a,b,op}, and the state_t enum {IDLE,BUSY,ARST,RESP}.
//  Sub-module tinyalu_cmd_fifo: parameterised sync FIFO of alu_cmd_t
//   (push/pop/full/empty, registered output).
//  Top: FSM, timeout counter, ALU reset-pulse counter, response registers.
// TESTING
//  add A=8'h12 B=8'h34, model done after 1 cycle -> result 16'h0046, OK, start high until done only.
//  mul A=8'hFF B=8'hFF, done after 3 cycles -> result 16'hFE01, OK, alu_A/B/op stable while start=1.
//  6 back-to-back cmds with rsp_ready=0 -> exactly 5 accepted, cmd_ready=0.
//   Then release rsp_ready -> 5 responses in order, the 6th accepted afterwards.
//  Model never asserts done -> start drops after 15 BUSY cycles, alu_reset_n low 2 cycles,
//   then result 0, TIMEOUT.
//  rst_op -> alu_reset_n low 2 cycles, no start, result 0, OK.
//   op=3'b101 -> ILLEGAL, no start. no_op -> result 0, OK.
//  Reset asserted mid-mul -> next cycle alu_start=0, rsp_valid=0, alu_reset_n=0.
//   After release: FIFO empty, cmd_ready=1, no stale response.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// Shared types for the TinyALU command issuer.
//   operation_t  : ALU opcode (3'b101 and 3'b110 are unused encodings)
//   rsp_status_t : status returned with every response
//   alu_cmd_t    : one buffered command {a, b, op}
//   state_t      : issuer FSM states
package tinyalu_pkg;

  typedef enum logic [2:0] {
    NoOp  = 3'b000,
    AddOp = 3'b001,
    AndOp = 3'b010,
    XorOp = 3'b011,
    MulOp = 3'b100,
    RstOp = 3'b111
  } operation_t;

  typedef enum logic [1:0] {
    StatusOk      = 2'b00,
    StatusTimeout = 2'b01,
    StatusIllegal = 2'b10
  } rsp_status_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    operation_t op;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StArst,
    StResp
  } state_t;

  // Ops that need the external ALU (everything else is answered locally).
  function automatic logic is_alu_op(operation_t op);
    return (op == AddOp) || (op == AndOp) || (op == XorOp) || (op == MulOp);
  endfunction

endpackage

// File: rtl/tinyalu_cmd_issuer_if.sv
// Bundle of the issuer's command stream, response stream and ALU-side signals.
//   slave  : issuer view (consumes commands, produces responses, drives the ALU)
//   master : environment view (command source, response sink, ALU model)
interface tinyalu_cmd_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic [1:0]  rsp_status;

  logic [7:0]  alu_A;
  logic [7:0]  alu_B;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_reset_n;
  logic        alu_done;
  logic [15:0] alu_result;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_done, alu_result,
    output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_status,
    output alu_A, alu_B, alu_op, alu_start, alu_reset_n
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_done, alu_result,
    input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_status,
    input  alu_A, alu_B, alu_op, alu_start, alu_reset_n
  );
endinterface

// File: rtl/tinyalu_cmd_fifo.sv
// Synchronous FIFO of alu_cmd_t with synchronous active-high reset.
//   push_i/wdata_i : write (ignored when full)
//   pop_i/rdata_o  : head entry read from the storage registers; pop ignored when empty
//   empty_o        : no entries
//   full_next_o    : FIFO will be full after this cycle's push/pop
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module tinyalu_cmd_fifo
  import tinyalu_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  alu_cmd_t wdata_i,
  input  logic     pop_i,
  output alu_cmd_t rdata_o,
  output logic     empty_o,
  output logic     full_next_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  typedef logic [PtrW:0] ptr_t;

  ptr_t     wr_ptr_q, wr_ptr_d;
  ptr_t     rd_ptr_q, rd_ptr_d;
  alu_cmd_t mem_q [Depth];
  logic     full, do_push, do_pop;

  function automatic logic ptr_full(ptr_t wr, ptr_t rd);
    return (wr[PtrW] != rd[PtrW]) && (wr[PtrW-1:0] == rd[PtrW-1:0]);
  endfunction

  assign full    = ptr_full(wr_ptr_q, rd_ptr_q);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    do_push  = push_i && !full;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    full_next_o = ptr_full(wr_ptr_d, rd_ptr_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/tinyalu_cmd_issuer.sv
// TinyALU command issuer: buffers commands, runs the ALU start/done handshake one op at
// a time and returns tagged responses in command order.
//   clk, reset : clock, synchronous active-high reset
//   bus        : cmd_* stream in, rsp_* stream out, alu_* towards/from the ALU
// no_op, rst_op and unused encodings are answered without starting the ALU; an ALU that
// never raises done is aborted after TIMEOUT busy cycles and reset for RST_CYCLES.
module tinyalu_cmd_issuer
  import tinyalu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  tinyalu_cmd_issuer_if.slave  bus
);

  localparam int unsigned BusyCntW = $clog2(TIMEOUT + 1);
  localparam int unsigned RstCntW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

  state_t              state_q, state_d;
  logic [BusyCntW-1:0] busy_cnt_q, busy_cnt_d;
  logic [RstCntW-1:0]  rst_cnt_q, rst_cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                alu_start_q, alu_start_d;
  logic [7:0]          alu_a_q, alu_a_d;
  logic [7:0]          alu_b_q, alu_b_d;
  operation_t          alu_op_q, alu_op_d;
  logic                alu_reset_n_q, alu_reset_n_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [15:0]         rsp_result_q, rsp_result_d;
  logic [2:0]          rsp_op_q, rsp_op_d;
  rsp_status_t         rsp_status_q, rsp_status_d;

  alu_cmd_t fifo_wdata, fifo_head;
  logic     fifo_push, fifo_pop, fifo_empty, fifo_full_next;

  // cmd_ready is registered, so a push never relies on a same-cycle pop freeing space.
  assign fifo_push  = bus.cmd_valid && cmd_ready_q;
  assign fifo_wdata = '{a: bus.cmd_a, b: bus.cmd_b, op: operation_t'(bus.cmd_op)};

  tinyalu_cmd_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .wdata_i     (fifo_wdata),
    .pop_i       (fifo_pop),
    .rdata_o     (fifo_head),
    .empty_o     (fifo_empty),
    .full_next_o (fifo_full_next)
  );

  always_comb begin
    state_d       = state_q;
    busy_cnt_d    = busy_cnt_q;
    rst_cnt_d     = rst_cnt_q;
    cmd_ready_d   = !fifo_full_next;
    alu_start_d   = alu_start_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    alu_reset_n_d = 1'b1;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_op_d      = rsp_op_q;
    rsp_status_d  = rsp_status_q;
    fifo_pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          rsp_result_d = '0;
          rsp_op_d     = fifo_head.op;
          rsp_status_d = StatusOk;
          if (is_alu_op(fifo_head.op)) begin
            alu_a_d     = fifo_head.a;
            alu_b_d     = fifo_head.b;
            alu_op_d    = fifo_head.op;
            alu_start_d = 1'b1;
            busy_cnt_d  = BusyCntW'(1);
            state_d     = StBusy;
          end else if (fifo_head.op == RstOp) begin
            alu_reset_n_d = 1'b0;
            rst_cnt_d     = RstCntW'(1);
            state_d       = StArst;
          end else begin
            if (fifo_head.op != NoOp) rsp_status_d = StatusIllegal;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
          end
        end
      end
      StBusy: begin
        rsp_op_d = alu_op_q;
        // Done is checked first so a done on the final allowed cycle still counts.
        if (bus.alu_done) begin
          alu_start_d  = 1'b0;
          rsp_result_d = bus.alu_result;
          rsp_status_d = StatusOk;
          rsp_valid_d  = 1'b1;
          state_d      = StResp;
        end else if (busy_cnt_q == BusyCntW'(TIMEOUT)) begin
          alu_start_d   = 1'b0;
          alu_reset_n_d = 1'b0;
          rst_cnt_d     = RstCntW'(1);
          rsp_result_d  = '0;
          rsp_status_d  = StatusTimeout;
          state_d       = StArst;
        end else begin
          busy_cnt_d = busy_cnt_q + BusyCntW'(1);
        end
      end
      StArst: begin
        if (rst_cnt_q == RstCntW'(RST_CYCLES)) begin
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          alu_reset_n_d = 1'b0;
          rst_cnt_d     = rst_cnt_q + RstCntW'(1);
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d  = 1'b0;
          rsp_result_d = '0;
          rsp_op_d     = '0;
          rsp_status_d = StatusOk;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      busy_cnt_q    <= '0;
      rst_cnt_q     <= '0;
      cmd_ready_q   <= 1'b0;
      alu_start_q   <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= NoOp;
      alu_reset_n_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_op_q      <= '0;
      rsp_status_q  <= StatusOk;
    end else begin
      state_q       <= state_d;
      busy_cnt_q    <= busy_cnt_d;
      rst_cnt_q     <= rst_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      alu_start_q   <= alu_start_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      alu_reset_n_q <= alu_reset_n_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_op_q      <= rsp_op_d;
      rsp_status_q  <= rsp_status_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.alu_A       = alu_a_q;
  assign bus.alu_B       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_start   = alu_start_q;
  assign bus.alu_reset_n = alu_reset_n_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_op      = rsp_op_q;
  assign bus.rsp_status  = rsp_status_q;

endmodule

// File: tb/tb_tinyalu_cmd_issuer.sv
// Self-checking bench for tinyalu_cmd_issuer: behavioural ALU model, response monitor and
// a scoreboard of expected responses computed from the command stream.
module tb_tinyalu_cmd_issuer;
  import tinyalu_pkg::*;

  typedef struct packed {
    logic [15:0] result;
    logic [2:0]  op;
    logic [1:0]  status;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tinyalu_cmd_issuer_if bus ();

  tinyalu_cmd_issuer #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (15),
    .RST_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_checks, n_fails;
  int   alu_lat;  // cycles of start before done; 0 = ALU never answers
  rsp_t got_q[$];
  rsp_t exp_q[$];
  int   got_idx;
  int   start_cycles, rstn_low_cycles, rsp_valid_cycles, accepted, unstable;

  function automatic logic [15:0] alu_calc(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    case (op)
      3'b001:  return {8'h00, a} + {8'h00, b};
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return {8'h00, a} * {8'h00, b};
      default: return 16'h0000;
    endcase
  endfunction

  // Expected response for one accepted command given the ALU behaviour in force.
  function automatic rsp_t ref_rsp(logic [7:0] a, logic [7:0] b, logic [2:0] op, int lat);
    rsp_t r;
    r.op = op;
    r.result = 16'h0000;
    r.status = 2'b00;
    if (op >= 3'b001 && op <= 3'b100) begin
      if (lat == 0 || lat > 15) r.status = 2'b01;
      else r.result = alu_calc(a, b, op);
    end else if (op == 3'b101 || op == 3'b110) begin
      r.status = 2'b10;
    end
    return r;
  endfunction

  // ALU model: done for one cycle after alu_lat cycles of start.
  initial begin : alu_model
    int cnt;
    cnt = 0;
    bus.alu_done = 1'b0;
    bus.alu_result = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.alu_reset_n !== 1'b1) begin
        cnt = 0;
        bus.alu_done = 1'b0;
      end else if (bus.alu_done) begin
        cnt = 0;
        bus.alu_done = 1'b0;
      end else if (bus.alu_start === 1'b1) begin
        cnt++;
        if (alu_lat != 0 && cnt == alu_lat) begin
          bus.alu_done = 1'b1;
          bus.alu_result = alu_calc(bus.alu_A, bus.alu_B, bus.alu_op);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : monitor
    logic        prev_start;
    logic [18:0] prev_alu;
    rsp_t        r;
    prev_start = 1'b0;
    prev_alu = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (bus.alu_start) start_cycles++;
        if (bus.alu_start && prev_start && {bus.alu_A, bus.alu_B, bus.alu_op} != prev_alu)
          unstable++;
        if (!bus.alu_reset_n) rstn_low_cycles++;
        if (bus.rsp_valid) rsp_valid_cycles++;
        if (bus.rsp_valid && bus.rsp_ready) begin
          r.result = bus.rsp_result;
          r.op = bus.rsp_op;
          r.status = bus.rsp_status;
          got_q.push_back(r);
        end
        if (bus.cmd_valid && bus.cmd_ready) accepted++;
      end
      prev_start = bus.alu_start;
      prev_alu = {bus.alu_A, bus.alu_B, bus.alu_op};
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one command until accepted; returns one cycle after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      output bit ok);
    int budget;
    budget = 200;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    while (!bus.cmd_ready && budget > 0) begin
      cyc(1);
      budget--;
    end
    ok = bus.cmd_ready;
    if (ok) exp_q.push_back(ref_rsp(a, b, op, alu_lat));
    cyc(1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    int budget;
    budget = 400;
    while (got_q.size() < got_idx + n && budget > 0) begin
      cyc(1);
      budget--;
    end
    ok = (got_q.size() >= got_idx + n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    n_checks++;
    if (bus.cmd_ready !== 1'b0) begin
      n_fails++; $display("FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready);
    end
    n_checks++;
    if ({bus.rsp_valid, bus.alu_start, bus.alu_reset_n} !== 3'b000) begin
      n_fails++;
      $display("FAIL reset_ctrl: got rsp_valid/start/reset_n=%b%b%b want 000",
               bus.rsp_valid, bus.alu_start, bus.alu_reset_n);
    end
    n_checks++;
    if ({bus.alu_A, bus.alu_B, bus.alu_op} !== 19'h0) begin
      n_fails++; $display("FAIL reset_alu_bus: got %h want 0", {bus.alu_A, bus.alu_B, bus.alu_op});
    end
    n_checks++;
    if ({bus.rsp_result, bus.rsp_op, bus.rsp_status} !== 21'h0) begin
      n_fails++;
      $display("FAIL reset_rsp: got %h want 0", {bus.rsp_result, bus.rsp_op, bus.rsp_status});
    end
    reset = 1'b0;
    cyc(1);
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.alu_reset_n !== 1'b1) begin
      n_fails++;
      $display("FAIL post_reset: got cmd_ready=%b reset_n=%b want 1 1",
               bus.cmd_ready, bus.alu_reset_n);
    end
  endtask

  task automatic test_add();
    bit ok;
    int s0;
    rsp_t g, e;
    alu_lat = 1;
    s0 = start_cycles;
    send(8'h12, 8'h34, 3'b001, ok);
    n_checks++;
    if (bus.alu_start !== 1'b0) begin
      n_fails++; $display("FAIL add_start_n1: got %b want 0", bus.alu_start);
    end
    cyc(1);
    n_checks++;
    if (bus.alu_start !== 1'b1) begin
      n_fails++; $display("FAIL add_start_n2: got %b want 1", bus.alu_start);
    end
    cyc(1);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.alu_start !== 1'b0) begin
      n_fails++;
      $display("FAIL add_done_latency: got rsp_valid=%b start=%b want 1 0",
               bus.rsp_valid, bus.alu_start);
    end
    wait_rsp(1, ok);
    n_checks++;
    if (!ok) begin
      n_fails++; $display("FAIL add_rsp: got no response want 1");
      exp_q.delete(); got_idx = got_q.size();
    end else begin
      g = got_q[got_idx]; got_idx++; e = exp_q.pop_front();
      if (g !== e || g.result !== 16'h0046) begin
        n_fails++; $display("FAIL add_rsp: got %h want %h", g, e);
      end
    end
    n_checks++;
    if (start_cycles - s0 != 1) begin
      n_fails++; $display("FAIL add_start_len: got %0d want 1", start_cycles - s0);
    end
  endtask

  task automatic test_mul();
    bit ok;
    int s0, u0;
    rsp_t g, e;
    alu_lat = 3;
    s0 = start_cycles;
    u0 = unstable;
    send(8'hFF, 8'hFF, 3'b100, ok);
    wait_rsp(1, ok);
    n_checks++;
    if (!ok) begin
      n_fails++; $display("FAIL mul_rsp: got no response want 1");
      exp_q.delete(); got_idx = got_q.size();
    end else begin
      g = got_q[got_idx]; got_idx++; e = exp_q.pop_front();
      if (g !== e || g.result !== 16'hFE01) begin
        n_fails++; $display("FAIL mul_rsp: got %h want %h", g, e);
      end
    end
    n_checks++;
    if (start_cycles - s0 != 3 || unstable != u0) begin
      n_fails++;
      $display("FAIL mul_start: got len=%0d unstable=%0d want 3 0",
               start_cycles - s0, unstable - u0);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int s0, r0;
    rsp_t g, e;
    for (int k = 0; k < 2; k++) begin
      // k=0: ALU silent; k=1: done on the last allowed busy cycle.
      alu_lat = (k == 0) ? 0 : 15;
      s0 = start_cycles;
      r0 = rstn_low_cycles;
      send(8'h21, 8'h43, 3'b011, ok);
      wait_rsp(1, ok);
      n_checks++;
      if (!ok) begin
        n_fails++; $display("FAIL timeout_rsp%0d: got no response want 1", k);
        exp_q.delete(); got_idx = got_q.size();
      end else begin
        g = got_q[got_idx]; got_idx++; e = exp_q.pop_front();
        if (g !== e) begin
          n_fails++; $display("FAIL timeout_rsp%0d: got %h want %h", k, g, e);
        end
      end
      n_checks++;
      if (start_cycles - s0 != 15 || rstn_low_cycles - r0 != ((k == 0) ? 2 : 0)) begin
        n_fails++;
        $display("FAIL timeout_pulses%0d: got start=%0d rstn_low=%0d want 15 %0d", k,
                 start_cycles - s0, rstn_low_cycles - r0, (k == 0) ? 2 : 0);
      end
    end
  endtask

  task automatic test_local_ops();
    bit ok;
    int s0, r0;
    rsp_t g, e;
    logic [2:0] ops[4];
    ops[0] = 3'b111; ops[1] = 3'b101; ops[2] = 3'b110; ops[3] = 3'b000;
    alu_lat = 1;
    s0 = start_cycles;
    r0 = rstn_low_cycles;
    for (int i = 0; i < 4; i++) send(8'($urandom), 8'($urandom), ops[i], ok);
    wait_rsp(4, ok);
    n_checks++;
    if (!ok) begin
      n_fails++; $display("FAIL local_rsp: got %0d responses want 4", got_q.size() - got_idx);
      exp_q.delete(); got_idx = got_q.size();
    end
    while (ok && exp_q.size() > 0) begin
      g = got_q[got_idx]; got_idx++; e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fails++; $display("FAIL local_rsp op%0d: got %h want %h", e.op, g, e);
      end
    end
    n_checks++;
    if (start_cycles - s0 != 0 || rstn_low_cycles - r0 != 2) begin
      n_fails++;
      $display("FAIL local_pulses: got start=%0d rstn_low=%0d want 0 2",
               start_cycles - s0, rstn_low_cycles - r0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, took;
    int i, a0, budget;
    rsp_t g, e;
    logic [7:0] ca[6], cb[6];
    logic [2:0] co[6];
    for (int k = 0; k < 6; k++) begin
      ca[k] = 8'($urandom); cb[k] = 8'($urandom); co[k] = 3'($urandom_range(1, 4));
    end
    alu_lat = 1;
    bus.rsp_ready = 1'b0;
    a0 = accepted;
    i = 0;
    bus.cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.cmd_a = ca[i]; bus.cmd_b = cb[i]; bus.cmd_op = co[i];
      took = bus.cmd_ready;
      if (took) exp_q.push_back(ref_rsp(ca[i], cb[i], co[i], alu_lat));
      cyc(1);
      if (took && i < 5) i++;
      else if (took) bus.cmd_valid = 1'b0;
    end
    n_checks++;
    if (accepted - a0 != 5 || i != 5) begin
      n_fails++; $display("FAIL b2b_accepted: got %0d want 5", accepted - a0);
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b0 || got_q.size() != got_idx) begin
      n_fails++;
      $display("FAIL b2b_stall: got cmd_ready=%b responses=%0d want 0 0",
               bus.cmd_ready, got_q.size() - got_idx);
    end
    bus.rsp_ready = 1'b1;
    budget = 200;
    while (!bus.cmd_ready && budget > 0) begin
      cyc(1);
      budget--;
    end
    if (bus.cmd_ready) exp_q.push_back(ref_rsp(ca[5], cb[5], co[5], alu_lat));
    cyc(1);
    bus.cmd_valid = 1'b0;
    wait_rsp(6, ok);
    n_checks++;
    if (!ok || exp_q.size() != 6) begin
      n_fails++;
      $display("FAIL b2b_rsp_count: got %0d want 6", got_q.size() - got_idx);
      exp_q.delete(); got_idx = got_q.size();
    end
    while (exp_q.size() > 0) begin
      g = got_q[got_idx]; got_idx++; e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fails++; $display("FAIL b2b_rsp: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_random();
    bit ok, sending;
    int misses;
    rsp_t g, e;
    for (int b = 0; b < 4; b++) begin
      alu_lat = $urandom_range(1, 4);
      sending = 1'b1;
      misses = 0;
      fork
        begin
          for (int k = 0; k < 8; k++) begin
            send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), ok);
            if (!ok) misses++;
          end
          sending = 1'b0;
        end
        begin
          while (sending) begin
            bus.rsp_ready = 1'($urandom_range(0, 1));
            cyc(1);
          end
        end
      join
      bus.rsp_ready = 1'b1;
      wait_rsp(8, ok);
      n_checks++;
      if (!ok || misses != 0) begin
        n_fails++;
        $display("FAIL rand_rsp_count%0d: got %0d want 8", b, got_q.size() - got_idx);
        exp_q.delete(); got_idx = got_q.size();
      end
      while (exp_q.size() > 0) begin
        g = got_q[got_idx]; got_idx++; e = exp_q.pop_front();
        n_checks++;
        if (g !== e) begin
          n_fails++; $display("FAIL rand_rsp%0d: got %h want %h", b, g, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int budget, s0, v0, g0;
    alu_lat = 0;
    bus.rsp_ready = 1'b1;
    send(8'h0F, 8'hF0, 3'b100, ok);
    send(8'h01, 8'h02, 3'b001, ok);
    budget = 50;
    while (bus.alu_start !== 1'b1 && budget > 0) begin
      cyc(1);
      budget--;
    end
    n_checks++;
    if (bus.alu_start !== 1'b1) begin
      n_fails++; $display("FAIL midrst_start: got %b want 1", bus.alu_start);
    end
    cyc(2);
    reset = 1'b1;
    cyc(1);
    n_checks++;
    if ({bus.alu_start, bus.rsp_valid, bus.alu_reset_n, bus.cmd_ready} !== 4'b0000) begin
      n_fails++;
      $display("FAIL midrst_outputs: got start/rsp_valid/reset_n/cmd_ready=%b%b%b%b want 0000",
               bus.alu_start, bus.rsp_valid, bus.alu_reset_n, bus.cmd_ready);
    end
    cyc(1);
    reset = 1'b0;
    exp_q.delete();
    alu_lat = 1;
    s0 = start_cycles;
    v0 = rsp_valid_cycles;
    g0 = got_q.size();
    cyc(20);
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.alu_reset_n !== 1'b1) begin
      n_fails++;
      $display("FAIL midrst_after: got cmd_ready=%b reset_n=%b want 1 1",
               bus.cmd_ready, bus.alu_reset_n);
    end
    n_checks++;
    if (start_cycles != s0 || rsp_valid_cycles != v0 || got_q.size() != g0) begin
      n_fails++;
      $display("FAIL midrst_stale: got start=%0d rsp_valid=%0d want 0 0",
               start_cycles - s0, rsp_valid_cycles - v0);
    end
    got_idx = got_q.size();
  endtask

  initial begin
    n_checks = 0;
    n_fails = 0;
    got_idx = 0;
    start_cycles = 0;
    rstn_low_cycles = 0;
    rsp_valid_cycles = 0;
    accepted = 0;
    unstable = 0;
    alu_lat = 1;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = 8'h00;
    bus.cmd_b = 8'h00;
    bus.cmd_op = 3'b000;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_add();
    test_mul();
    test_timeout();
    test_local_ops();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
